ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- Single-outstanding AHB master that sits directly upstream of the AHB slave. It converts a core-side valid/ready request into one AHB transfer (address phase, then data phase) and returns read data or error through a valid/ready response channel.
- It drives the slave's hdata_m2s/haddr_m2s/hwrite/hsel inputs and consumes its hready/hresp/hrdata.
- A wait-state timeout counter guarantees forward progress when the slave never asserts hready.

Parameters:
- ADDR_W, 32, address width; matches `AHB_ADDR_WIDTH.
- DATA_W, 32, data width; matches `AHB_DATA_WIDTH.
- TIMEOUT, 16, consecutive hready-low data-phase cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  synchronous, active-high reset. Asserted = 1, sampled on the clk edge. The name is kept for codebase consistency; the polarity is fixed as stated.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  transfer address, passed through unmodified.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for aborted transfers.
- rsp_err  out  1  1 = slave error or timeout.
- haddr_m2s  out  ADDR_W  AHB address.
- hdata_m2s  out  DATA_W  AHB write data.
- hwrite  out  1  AHB direction.
- hsel  out  1  AHB select; high in the address phase only.
- hready  in  1  slave ready.
- hresp  in  1  slave error; valid only when hready = 1.
- hrdata  in  DATA_W  slave read data.

Behaviour:
- Reset values:
  - state = IDLE.
  - req_ready = 1.
  - rsp_valid, rsp_err, rsp_rdata, hsel, hwrite, haddr_m2s, hdata_m2s and the wait counter are all 0.
- Outputs: req_ready = (state == IDLE), combinational from state. Every other output is registered.
- FSM has four states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On req_valid & req_ready, register haddr_m2s <= req_addr and hwrite <= req_write.
  - hdata_m2s <= req_wdata for a write, 0 for a read.
  - hsel <= 1; go to ADDR.
  - Otherwise hold.
- ADDR (exactly 1 cycle):
  - hsel = 1; haddr_m2s and hwrite are valid.
  - Next edge: hsel <= 0, wait counter <= 0, go to DATA. haddr_m2s, hwrite and hdata_m2s hold.
- DATA:
  - hready = 1: rsp_valid <= 1, rsp_err <= hresp, go to RESP. rsp_rdata <= hrdata for a read, 0 for a write.
  - hready = 0 and TIMEOUT != 0: counter increments. When the counter reaches TIMEOUT-1 with hready still 0, complete with rsp_err <= 1 and rsp_rdata <= 0; go to RESP.
  - hresp is ignored while hready = 0.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready = 1.
  - On that edge: rsp_valid <= 0, go to IDLE. The AHB outputs return to 0 (hwrite, haddr_m2s, hdata_m2s).
- Latency, with the request accepted at edge 0:
  - hsel high during cycle 1.
  - Data phase starts cycle 2.
  - With zero wait states, rsp_valid is high from edge 3.
  - Each hready-low cycle adds 1.
  - Best-case throughput is one transfer per 4 cycles, given rsp_ready tied high.
- Only one transfer is ever outstanding; req_valid outside IDLE is not accepted.
- A new request may be accepted in the first IDLE cycle after the response handshake, never in the same cycle.
- Counter width is $clog2(TIMEOUT+1), minimum 1. It saturates and never wraps.
- Reset mid-operation: the transfer is dropped, no response is produced, and all outputs take their reset values at the resetting edge. Reset has priority over every other event.
- rsp_ready asserted while rsp_valid = 0 has no effect.

Test Plan:
- Write, zero wait states.
  - Stimulus: req addr=0x0000_1000, wdata=0xDEAD_BEEF, write=1; hready=1, hresp=0.
  - Required: hsel=1 with haddr_m2s=0x1000 and hwrite=1 in cycle 1; hdata_m2s=0xDEADBEEF in cycle 2; rsp_valid at edge 3 with rsp_err=0 and rsp_rdata=0.
- Read, 3 wait states.
  - Stimulus: read addr=0x20; hready low for 3 cycles, then high with hrdata=0x1234_5678.
  - Required: rsp_valid at edge 6 with rsp_rdata=0x12345678 and rsp_err=0.
- Slave error.
  - Stimulus: a read where hready=1 and hresp=1 in the data phase.
  - Required: rsp_err=1 with rsp_rdata=hrdata. A hresp=1 pulse during an earlier hready=0 cycle must be ignored.
- Timeout.
  - Stimulus: TIMEOUT=4, hready held 0.
  - Required: rsp_valid with rsp_err=1 and rsp_rdata=0 after exactly 4 data-phase cycles. With TIMEOUT=0, no response after 100 cycles.
- Response backpressure.
  - Stimulus: rsp_ready=0 for 5 cycles, with req_valid held high carrying a second request.
  - Required: rsp fields stay stable and req_ready=0 throughout. The second request is accepted only in the cycle after the rsp handshake.
- Reset mid-DATA.
  - Stimulus: assert rstn=1 for 1 cycle while hready=0 in the data phase.
  - Required: all outputs are 0 and req_ready=1 after the edge; no rsp_valid ever appears for the dropped request.

Source files
------------

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master.
//
// Turns one core-side request (valid/ready) into one AHB transfer: a single
// address-phase cycle with hsel high, then a data phase that lasts until the
// slave raises hready. The result (read data, error flag) comes back on a
// valid/ready response channel. A wait-state counter aborts the data phase
// with an error if the slave stalls for TIMEOUT consecutive cycles
// (TIMEOUT = 0 disables the abort).
//
// Ports
//   clk, rstn                 clock; synchronous active-high reset
//   req_valid/req_ready       request handshake (req_ready high only in idle)
//   req_write/addr/wdata      request payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_err         response payload (rdata is 0 for writes/aborts)
//   haddr_m2s/hdata_m2s       AHB address / write data
//   hwrite/hsel               AHB direction / select (hsel in address phase)
//   hready/hresp/hrdata       AHB slave ready / error / read data

module ahb_lite_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    // Request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // Response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // AHB side
    output logic [ADDR_W-1:0] haddr_m2s,
    output logic [DATA_W-1:0] hdata_m2s,
    output logic              hwrite,
    output logic              hsel,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);

    // Counter must hold values up to TIMEOUT-1; keep at least one bit so the
    // declaration stays legal when the timeout is disabled.
    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                hsel_q, hsel_d;
    logic                hwrite_q, hwrite_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic [DATA_W-1:0]   hdata_q, hdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= StIdle;
            hsel_q      <= 1'b0;
            hwrite_q    <= 1'b0;
            haddr_q     <= '0;
            hdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hsel_q      <= hsel_d;
            hwrite_q    <= hwrite_d;
            haddr_q     <= haddr_d;
            hdata_q     <= hdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        hsel_d      = hsel_q;
        hwrite_d    = hwrite_q;
        haddr_d     = haddr_q;
        hdata_d     = hdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;

        case (state_q)
            StIdle: begin
                // req_ready is high in this state, so req_valid alone is a handshake.
                if (req_valid) begin
                    haddr_d  = req_addr;
                    hwrite_d = req_write;
                    hdata_d  = req_write ? req_wdata : '0;
                    hsel_d   = 1'b1;
                    state_d  = StAddr;
                end
            end

            StAddr: begin
                hsel_d  = 1'b0;
                cnt_d   = '0;
                state_d = StData;
            end

            StData: begin
                if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = hresp;
                    rsp_rdata_d = hwrite_q ? '0 : hrdata;
                    state_d     = StResp;
                end else if (TIMEOUT != 0) begin
                    // hresp is meaningless while the slave is stalling.
                    if (cnt_q == CntLast) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = StResp;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    hwrite_d    = 1'b0;
                    haddr_d     = '0;
                    hdata_d     = '0;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign haddr_m2s = haddr_q;
    assign hdata_m2s = hdata_q;
    assign hwrite    = hwrite_q;
    assign hsel      = hsel_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
`timescale 1ns/1ps
module tb_ahb_lite_master;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] haddr_m2s;
    logic [31:0] hdata_m2s;
    logic        hwrite;
    logic        hsel;
    logic        hready = 1'b0;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = '0;

    // Second instance with the timeout disabled
    logic        nt_req_valid = 1'b0;
    logic        nt_req_ready;
    logic        nt_rsp_valid;
    logic [31:0] nt_rsp_rdata;
    logic        nt_rsp_err;
    logic [31:0] nt_haddr;
    logic [31:0] nt_hdata;
    logic        nt_hwrite;
    logic        nt_hsel;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned acc;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    logic        rv_prev = 1'b0;
    logic [31:0] held_rdata = '0;
    logic        held_err = 1'b0;

    ahb_lite_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .haddr_m2s (haddr_m2s),
        .hdata_m2s (hdata_m2s),
        .hwrite    (hwrite),
        .hsel      (hsel),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    ahb_lite_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (0)
    ) u_dut_nt (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (nt_req_valid),
        .req_ready (nt_req_ready),
        .req_write (1'b0),
        .req_addr  (32'h0000_0044),
        .req_wdata (32'h0),
        .rsp_valid (nt_rsp_valid),
        .rsp_ready (1'b1),
        .rsp_rdata (nt_rsp_rdata),
        .rsp_err   (nt_rsp_err),
        .haddr_m2s (nt_haddr),
        .hdata_m2s (nt_hdata),
        .hwrite    (nt_hwrite),
        .hsel      (nt_hsel),
        .hready    (1'b0),
        .hresp     (1'b0),
        .hrdata    (32'hFFFF_FFFF)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag, input logic full);
        check_val({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        check_val({tag, "_hsel"}, {31'b0, hsel}, 32'd0);
        check_val({tag, "_hwrite"}, {31'b0, hwrite}, 32'd0);
        check_val({tag, "_haddr"}, haddr_m2s, 32'd0);
        check_val({tag, "_hdata"}, hdata_m2s, 32'd0);
        check_val({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        if (full) begin
            check_val({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
            check_val({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        end
    endtask

    // Response monitor: pops the scoreboard on each new response and checks
    // that a held response does not change while backpressured.
    always @(negedge clk) begin
        if (rsp_valid && !rv_prev) begin
            if (sb.size() == 0) begin
                check_val("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("rsp_rdata", rsp_rdata, e.rdata);
                check_val("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                check_val("rsp_latency", cyc - e.acc, e.lat);
            end
            held_rdata = rsp_rdata;
            held_err   = rsp_err;
        end else if (rsp_valid && rv_prev) begin
            check_val("rsp_rdata_stable", rsp_rdata, held_rdata);
            check_val("rsp_err_stable", {31'b0, rsp_err}, {31'b0, held_err});
        end
        rv_prev = rsp_valid;
    end

    // One complete transfer with rsp_ready high. Called at a negedge with the
    // DUT idle; returns at the negedge of the following idle cycle.
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic resp_err, input logic [31:0] rd,
                            input logic glitch, input logic tmo);
        exp_t e;
        int   n_data;
        check_val("pre_req_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        hready    = 1'b0;
        hresp     = 1'b0;
        e.acc   = cyc;
        e.err   = tmo ? 1'b1 : resp_err;
        e.rdata = (w || tmo) ? 32'd0 : rd;
        e.lat   = tmo ? (2 + TO) : (3 + waits);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        check_val("addr_hsel", {31'b0, hsel}, 32'd1);
        check_val("addr_haddr", haddr_m2s, a);
        check_val("addr_hwrite", {31'b0, hwrite}, {31'b0, w});
        check_val("addr_req_ready", {31'b0, req_ready}, 32'd0);
        n_data = tmo ? int'(TO) : waits + 1;
        for (int k = 0; k < n_data; k++) begin
            @(negedge clk);
            check_val("data_hsel", {31'b0, hsel}, 32'd0);
            check_val("data_hdata", hdata_m2s, w ? wd : 32'd0);
            hready = !tmo && (k == waits);
            hresp  = hready ? resp_err : glitch;
            hrdata = hready ? rd : 32'h5A5A_5A5A;
        end
        @(negedge clk);
        hready = 1'b0;
        hresp  = 1'b0;
        check_val("resp_valid", {31'b0, rsp_valid}, 32'd1);
        @(negedge clk);
        check_idle("post", 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_rsp;
        repeat (3) @(negedge clk);
        check_idle("reset", 1'b1);
        rstn = 1'b0;
        @(negedge clk);

        // Write, zero wait states
        run_xfer(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        // Read, 3 wait states (one short of the timeout)
        run_xfer(1'b0, 32'h0000_0020, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
        // Slave error; earlier hresp pulse while stalled must be ignored
        run_xfer(1'b0, 32'h0000_0040, 32'h0, 2, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0);
        // Stalled-cycle hresp pulse then OK completion
        run_xfer(1'b0, 32'h0000_0048, 32'h0, 1, 1'b0, 32'h0BEE_F00D, 1'b1, 1'b0);
        // Write with wait states: hdata must hold
        run_xfer(1'b1, 32'h0000_0060, 32'h7654_3210, 2, 1'b0, 32'h0, 1'b0, 1'b0);
        // Timeout
        run_xfer(1'b0, 32'h0000_0080, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Response backpressure with a second request waiting
        begin
            exp_t e;
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 32'h0000_0100;
            req_wdata = 32'h0;
            hready    = 1'b1;
            hresp     = 1'b0;
            hrdata    = 32'hA5A5_0001;
            e.acc = cyc; e.err = 1'b0; e.rdata = 32'hA5A5_0001; e.lat = 3;
            sb.push_back(e);
            @(negedge clk);
            req_write = 1'b1;
            req_addr  = 32'h0000_0200;
            req_wdata = 32'h0BAD_F00D;
            check_val("bp_addr_haddr", haddr_m2s, 32'h0000_0100);
            @(negedge clk);
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                check_val("bp_req_ready", {31'b0, req_ready}, 32'd0);
                check_val("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
                check_val("bp_hsel", {31'b0, hsel}, 32'd0);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            check_val("bp_req_ready_hs", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
            check_val("bp_req_ready_after", {31'b0, req_ready}, 32'd1);
            check_val("bp_rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
            check_val("bp_hsel_after", {31'b0, hsel}, 32'd0);
            e.acc = cyc; e.err = 1'b0; e.rdata = 32'd0; e.lat = 3;
            sb.push_back(e);
            @(negedge clk);
            req_valid = 1'b0;
            check_val("bp2_hsel", {31'b0, hsel}, 32'd1);
            check_val("bp2_haddr", haddr_m2s, 32'h0000_0200);
            check_val("bp2_hwrite", {31'b0, hwrite}, 32'd1);
            @(negedge clk);
            check_val("bp2_hdata", hdata_m2s, 32'h0BAD_F00D);
            @(negedge clk);
            hready = 1'b0;
            @(negedge clk);
            check_idle("bp2_post", 1'b0);
        end

        // Timeout disabled: stalled slave must never produce a response
        nt_req_valid = 1'b1;
        @(negedge clk);
        nt_req_valid = 1'b0;
        any_rsp = 1'b0;
        repeat (100) begin
            @(negedge clk);
            any_rsp = any_rsp | nt_rsp_valid;
        end
        check_val("nt_no_rsp", {31'b0, any_rsp}, 32'd0);
        check_val("nt_req_ready", {31'b0, nt_req_ready}, 32'd0);

        // Reset in the middle of the data phase
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0300;
        req_wdata = 32'h1111_2222;
        hready    = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_val("rst_in_data_hdata", hdata_m2s, 32'h1111_2222);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        check_idle("rst_mid", 1'b1);
        check_val("rst_nt_req_ready", {31'b0, nt_req_ready}, 32'd1);
        any_rsp = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_rsp = any_rsp | rsp_valid;
        end
        check_val("rst_no_rsp", {31'b0, any_rsp}, 32'd0);

        // Recovery after reset
        run_xfer(1'b0, 32'h0000_0400, 32'h0, 0, 1'b0, 32'h8765_4321, 1'b0, 1'b0);

        check_val("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
